// File: rtl/mac_array.sv
// Weight-stationary systolic MAC array: ROW input channels by COLUMN output channels,
// with internal activation skew, sideband pipeline, backpressure and double-buffered weights.
module mac_array #(
  parameter int unsigned DW     = 8,
  parameter int unsigned WW     = 8,
  parameter int unsigned PW     = 21,
  parameter int unsigned ROW    = 8,
  parameter int unsigned COLUMN = 6,
  parameter bit          SIGNED = 1'b1,
  localparam int unsigned RW    = (ROW > 1) ? $clog2(ROW) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROW*DW-1:0]      mac_m_data,
  input  logic [COLUMN*PW-1:0]   mac_m_ci,
  input  logic                   mac_m_first,
  input  logic                   mac_m_last,
  input  logic                   mac_m_valid,
  output logic                   mac_m_ready,
  input  logic [COLUMN*WW-1:0]   w_data,
  input  logic [RW-1:0]          w_row,
  input  logic                   w_we,
  output logic                   w_ready,
  input  logic                   w_swap,
  output logic                   act_bank,
  output logic [COLUMN*PW-1:0]   mac_s_data,
  output logic                   mac_s_first,
  output logic                   mac_s_last,
  output logic                   mac_s_valid,
  input  logic                   mac_s_ready
);

  logic                           adv;
  logic                           wr_en;
  logic                           shadow;
  logic [WW-1:0]                  w_mem [2][ROW][COLUMN];
  logic [ROW-1:0]                 st_valid;
  logic [ROW-1:0]                 st_first;
  logic [ROW-1:0]                 st_last;
  logic [ROW-1:0]                 st_bank;
  logic [ROW-1:0][COLUMN*PW-1:0]  st_psum;
  logic [ROW-1:0][DW-1:0]         act_d;

  function automatic logic [PW-1:0] ext_x(input logic [DW-1:0] v);
    if (SIGNED) return PW'($signed(v));
    else        return PW'(v);
  endfunction

  function automatic logic [PW-1:0] ext_w(input logic [WW-1:0] v);
    if (SIGNED) return PW'($signed(v));
    else        return PW'(v);
  endfunction

  assign adv         = !st_valid[ROW-1] || mac_s_ready;
  assign mac_m_ready = adv;
  assign shadow      = ~act_bank;
  assign wr_en       = w_we && w_ready && (32'(w_row) < ROW);

  // Shadow bank is writable only once no in-flight beat still references it
  always_comb begin
    w_ready = 1'b1;
    for (int unsigned r = 0; r < ROW; r++) begin
      if (st_valid[r] && (st_bank[r] != act_bank)) w_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      act_bank <= 1'b0;
    else if (w_swap) act_bank <= ~act_bank;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned r = 0; r < ROW; r++)
          for (int unsigned c = 0; c < COLUMN; c++)
            w_mem[b][r][c] <= '0;
    end else if (wr_en) begin
      for (int unsigned r = 0; r < ROW; r++) begin
        if (w_row == RW'(r)) begin
          for (int unsigned c = 0; c < COLUMN; c++)
            w_mem[shadow][r][c] <= w_data[c*WW +: WW];
        end
      end
    end
  end

  // Row r activation is delayed r advancing cycles to meet its beat at stage r
  for (genvar r = 0; r < ROW; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign act_d[r] = mac_m_data[0 +: DW];
    end else begin : g_delay
      logic [DW-1:0] sr [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < r; k++) sr[k] <= '0;
        end else if (adv) begin
          sr[0] <= mac_m_data[r*DW +: DW];
          for (int k = 1; k < r; k++) sr[k] <= sr[k-1];
        end
      end
      assign act_d[r] = sr[r-1];
    end
  end

  for (genvar r = 0; r < ROW; r++) begin : g_stage
    logic                 v_i, f_i, l_i, b_i;
    logic                 v_q, f_q, l_q, b_q;
    logic [COLUMN*PW-1:0] ps_i;
    logic [COLUMN*PW-1:0] ps_d;
    logic [COLUMN*PW-1:0] ps_q;

    if (r == 0) begin : g_head
      assign v_i  = mac_m_valid;
      assign f_i  = mac_m_first;
      assign l_i  = mac_m_last;
      assign b_i  = act_bank;
      assign ps_i = mac_m_ci;
    end else begin : g_body
      assign v_i  = st_valid[r-1];
      assign f_i  = st_first[r-1];
      assign l_i  = st_last[r-1];
      assign b_i  = st_bank[r-1];
      assign ps_i = st_psum[r-1];
    end

    // Each beat multiplies with the bank it was tagged with at acceptance
    always_comb begin
      ps_d = '0;
      for (int unsigned c = 0; c < COLUMN; c++)
        ps_d[c*PW +: PW] = ps_i[c*PW +: PW] + ext_x(act_d[r]) * ext_w(w_mem[b_i][r][c]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        f_q  <= 1'b0;
        l_q  <= 1'b0;
        b_q  <= 1'b0;
        ps_q <= '0;
      end else if (adv) begin
        v_q  <= v_i;
        f_q  <= f_i;
        l_q  <= l_i;
        b_q  <= b_i;
        ps_q <= ps_d;
      end
    end

    assign st_valid[r] = v_q;
    assign st_first[r] = f_q;
    assign st_last[r]  = l_q;
    assign st_bank[r]  = b_q;
    assign st_psum[r]  = ps_q;
  end

  assign mac_s_data  = st_psum[ROW-1];
  assign mac_s_first = st_first[ROW-1];
  assign mac_s_last  = st_last[ROW-1];
  assign mac_s_valid = st_valid[ROW-1];

endmodule

// File: tb/tb_mac_array.sv
// Bench for mac_array: a signed and an unsigned instance share all stimulus;
// directed vectors plus an in-order reference queue with its own weight image.
module tb_mac_array;

  localparam int unsigned DW  = 8;
  localparam int unsigned WW  = 8;
  localparam int unsigned PW  = 21;
  localparam int unsigned ROW = 8;
  localparam int unsigned COL = 6;
  localparam int unsigned XW  = ROW*DW;
  localparam int unsigned CW  = COL*PW;
  localparam int unsigned WD  = COL*WW;

  logic          clk, rst_n;
  logic [XW-1:0] m_data;
  logic [CW-1:0] m_ci;
  logic          m_first, m_last, m_valid;
  logic          m_ready, u_m_ready;
  logic [WD-1:0] w_data;
  logic [2:0]    w_row;
  logic          w_we, w_swap;
  logic          w_ready, u_w_ready;
  logic          act_bank, u_act_bank;
  logic [CW-1:0] s_data, u_s_data;
  logic          s_first, u_s_first, s_last, u_s_last, s_valid, u_s_valid;
  logic          s_ready;

  mac_array #(.DW(DW), .WW(WW), .PW(PW), .ROW(ROW), .COLUMN(COL), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .mac_m_data(m_data), .mac_m_ci(m_ci),
    .mac_m_first(m_first), .mac_m_last(m_last), .mac_m_valid(m_valid), .mac_m_ready(m_ready),
    .w_data(w_data), .w_row(w_row), .w_we(w_we), .w_ready(w_ready), .w_swap(w_swap),
    .act_bank(act_bank), .mac_s_data(s_data), .mac_s_first(s_first), .mac_s_last(s_last),
    .mac_s_valid(s_valid), .mac_s_ready(s_ready));

  mac_array #(.DW(DW), .WW(WW), .PW(PW), .ROW(ROW), .COLUMN(COL), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .mac_m_data(m_data), .mac_m_ci(m_ci),
    .mac_m_first(m_first), .mac_m_last(m_last), .mac_m_valid(m_valid), .mac_m_ready(u_m_ready),
    .w_data(w_data), .w_row(w_row), .w_we(w_we), .w_ready(u_w_ready), .w_swap(w_swap),
    .act_bank(u_act_bank), .mac_s_data(u_s_data), .mac_s_first(u_s_first), .mac_s_last(u_s_last),
    .mac_s_valid(u_s_valid), .mac_s_ready(s_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] es;
    logic [CW-1:0] eu;
    logic          f;
    logic          l;
    logic          bank;
  } exp_t;

  typedef struct {
    logic [WW-1:0] wv;
    logic [XW-1:0] x;
    logic [PW-1:0] ci;
    logic          f;
    logic          l;
    logic [PW-1:0] es;
    logic [PW-1:0] eu;
  } vec_t;

  exp_t          q[$];
  vec_t          vt[7];
  logic [WW-1:0] wm [2][ROW][COL];
  logic          act_m;
  bit            stall_prev;
  bit            acc_flag;
  logic [CW-1:0] hold_s, hold_u;
  logic          hold_f, hold_l;
  logic [7:0]    lfsr;
  logic [127:0]  t128;
  int            n_vec, n_err, acc_n;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] model(input logic [XW-1:0] x, input logic [CW-1:0] ci,
                                          input logic b, input bit sgn);
    logic [CW-1:0] res;
    longint        acc;
    logic [7:0]    xv, wv;
    byte           sx, sw;
    res = '0;
    for (int c = 0; c < int'(COL); c++) begin
      acc = longint'(ci[c*PW +: PW]);
      for (int r = 0; r < int'(ROW); r++) begin
        xv = x[r*DW +: DW];
        wv = wm[b][r][c];
        sx = byte'(xv);
        sw = byte'(wv);
        if (sgn) acc += longint'(sx) * longint'(sw);
        else     acc += longint'(xv) * longint'(wv);
      end
      res[c*PW +: PW] = acc[PW-1:0];
    end
    return res;
  endfunction

  // One clock: entered and left at a negedge, inputs already set by the caller
  task automatic cycle();
    exp_t e;
    logic adv_m, wr_m;
    #1;
    if (stall_prev) begin
      chk("hold_data", 128'(s_data), 128'(hold_s));
      chk("hold_data_u", 128'(u_s_data), 128'(hold_u));
      chk("hold_flags", 128'({s_valid, s_first, s_last}), 128'({1'b1, hold_f, hold_l}));
    end
    adv_m = !s_valid || s_ready;
    chk("m_ready", 128'({m_ready, u_m_ready}), 128'({adv_m, adv_m}));
    wr_m = 1'b1;
    foreach (q[i]) if (q[i].bank != act_m) wr_m = 1'b0;
    chk("w_ready", 128'({w_ready, u_w_ready}), 128'({wr_m, wr_m}));
    chk("act_bank", 128'({act_bank, u_act_bank}), 128'({act_m, act_m}));
    chk("u_valid", 128'(u_s_valid), 128'(s_valid));
    if (s_valid && q.size() == 0) begin
      chk("spurious_out", 128'(s_valid), 128'(0));
    end else if (s_valid && s_ready) begin
      e = q.pop_front();
      chk("out_data_s", 128'(s_data), 128'(e.es));
      chk("out_data_u", 128'(u_s_data), 128'(e.eu));
      chk("out_flags", 128'({s_first, s_last}), 128'({e.f, e.l}));
    end
    stall_prev = s_valid && !s_ready;
    hold_s = s_data; hold_u = u_s_data; hold_f = s_first; hold_l = s_last;
    acc_flag = m_valid && adv_m;
    if (acc_flag) begin
      e.es = model(m_data, m_ci, act_m, 1'b1);
      e.eu = model(m_data, m_ci, act_m, 1'b0);
      e.f = m_first; e.l = m_last; e.bank = act_m;
      q.push_back(e);
    end
    if (w_we && wr_m && int'(w_row) < int'(ROW))
      for (int c = 0; c < int'(COL); c++) wm[!act_m][w_row][c] = w_data[c*WW +: WW];
    if (w_swap) act_m = !act_m;
    @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0; w_we = 1'b0; w_swap = 1'b0;
  endtask

  task automatic load_weights(input logic [WW-1:0] wv);
    for (int r = 0; r < int'(ROW); r++) begin
      w_we = 1'b1; w_row = 3'(r); w_data = {COL{wv}};
      cycle();
    end
    w_swap = 1'b1;
    cycle();
  endtask

  // Single beat on an empty pipeline: exact latency and hand-computed result
  task automatic run_beat(input string nm, input logic [XW-1:0] x, input logic [PW-1:0] ci,
                          input logic f, input logic l, input logic [PW-1:0] es, input logic [PW-1:0] eu);
    s_ready = 1'b1;
    m_valid = 1'b1; m_data = x; m_ci = {COL{ci}}; m_first = f; m_last = l;
    cycle();
    for (int i = 1; i <= int'(ROW); i++) begin
      chk({nm, "_latency"}, 128'(s_valid), 128'(i == int'(ROW)));
      if (i == int'(ROW)) begin
        chk({nm, "_signed"}, 128'(s_data), 128'({COL{es}}));
        chk({nm, "_unsigned"}, 128'(u_s_data), 128'({COL{eu}}));
        chk({nm, "_flags"}, 128'({s_first, s_last}), 128'({f, l}));
      end
      cycle();
    end
  endtask

  task automatic drain(input string nm);
    s_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
    chk({nm, "_drained"}, 128'(q.size()), 128'(0));
    chk({nm, "_idle"}, 128'({s_valid, w_ready}), 128'({1'b0, 1'b1}));
  endtask

  initial begin
    vt[0] = '{wv:8'h02, x:64'h03020100_FFFEFDFC, ci:21'd100,      f:1'b1, l:1'b1, es:21'd92,       eu:21'd2140};
    vt[1] = '{wv:8'h80, x:64'h80808080_80808080, ci:21'd0,        f:1'b1, l:1'b0, es:21'd131072,   eu:21'd131072};
    vt[2] = '{wv:8'h80, x:64'h0,                 ci:21'h0FFFFF,   f:1'b0, l:1'b1, es:21'h0FFFFF,   eu:21'h0FFFFF};
    vt[3] = '{wv:8'h01, x:64'h1,                 ci:21'h1FFFFF,   f:1'b0, l:1'b0, es:21'd0,        eu:21'd0};
    vt[4] = '{wv:8'hFF, x:64'hFFFFFFFF_FFFFFFFF, ci:21'd0,        f:1'b1, l:1'b1, es:21'd8,        eu:21'd520200};
    vt[5] = '{wv:8'hFE, x:64'h01010101_01010101, ci:21'h1FFFFF,   f:1'b0, l:1'b1, es:21'h1FFFEF,   eu:21'd2031};
    vt[6] = '{wv:8'h03, x:64'h01010101_01010101, ci:21'd5,        f:1'b1, l:1'b0, es:21'd29,       eu:21'd29};

    n_vec = 0; n_err = 0; act_m = 1'b0; stall_prev = 1'b0; lfsr = 8'hA5;
    rst_n = 1'b0; m_data = '0; m_ci = '0; m_first = 1'b0; m_last = 1'b0; m_valid = 1'b0;
    w_data = '0; w_row = '0; w_we = 1'b0; w_swap = 1'b0; s_ready = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < int'(ROW); r++)
        for (int c = 0; c < int'(COL); c++) wm[b][r][c] = '0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_valid", 128'({s_valid, u_s_valid}), 128'(0));
    chk("reset_data", 128'(s_data), 128'(0));
    chk("reset_bank", 128'(act_bank), 128'(0));
    chk("reset_ready", 128'({w_ready, m_ready}), 128'({1'b1, 1'b1}));

    // Directed single-beat vectors
    for (int i = 0; i < 7; i++) begin
      load_weights(vt[i].wv);
      run_beat($sformatf("vec%0d", i), vt[i].x, vt[i].ci, vt[i].f, vt[i].l, vt[i].es, vt[i].eu);
    end

    // Random streaming under LFSR backpressure
    for (int r = 0; r < int'(ROW); r++) begin
      t128 = {$urandom(), $urandom(), $urandom(), $urandom()};
      w_we = 1'b1; w_row = 3'(r); w_data = t128[WD-1:0];
      cycle();
    end
    w_swap = 1'b1;
    cycle();
    acc_n = 0;
    for (int k = 0; k < 400 && acc_n < 20; k++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      s_ready = lfsr[0];
      t128 = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_valid = 1'b1; m_data = {$urandom(), $urandom()}; m_ci = t128[CW-1:0];
      m_first = (acc_n == 0); m_last = (acc_n == 19);
      cycle();
      if (acc_flag) acc_n++;
    end
    chk("stream_accepted", 128'(acc_n), 128'(20));
    drain("stream");

    // Bank swap under traffic; a write into the still-busy shadow bank is dropped
    load_weights(8'd3);
    s_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t128 = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_valid = 1'b1; m_data = {$urandom(), $urandom()}; m_ci = t128[CW-1:0];
      if (i < 8) begin
        w_we = 1'b1; w_row = 3'(i); w_data = {COL{8'd1}};
      end
      if (i == 10) w_swap = 1'b1;
      if (i == 11) begin
        chk("swap_w_ready_low", 128'(w_ready), 128'(0));
        w_we = 1'b1; w_row = 3'd0; w_data = {COL{8'd7}};
      end
      cycle();
    end
    drain("swap");
    w_swap = 1'b1;
    cycle();
    run_beat("dropped_write", 64'h01010101_01010101, 21'd0, 1'b1, 1'b1, 21'd24, 21'd24);

    // Reset with beats in flight, then recover with freshly written weights
    if (act_m == 1'b0) begin
      w_swap = 1'b1;
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      m_valid = 1'b1; m_data = {$urandom(), $urandom()}; m_ci = '0;
      cycle();
    end
    chk("pre_reset_bank", 128'(act_bank), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 128'({s_valid, u_s_valid}), 128'(0));
    chk("mid_reset_bank", 128'(act_bank), 128'(0));
    chk("mid_reset_data", 128'(s_data), 128'(0));
    q.delete();
    act_m = 1'b0;
    stall_prev = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < int'(ROW); r++)
        for (int c = 0; c < int'(COL); c++) wm[b][r][c] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    load_weights(8'd5);
    run_beat("post_reset", 64'h02020202_02020202, 21'd1, 1'b0, 1'b1, 21'd81, 21'd81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
